// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM state encoding, line geometry and address/line slice helpers.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = 128;
  localparam int MEM_ADDR_W     = 28;
  localparam int PROC_ADDR_W    = 30;
  localparam int OFF_W          = 2;

  function automatic logic [MEM_ADDR_W-1:0] blk_addr(input logic [PROC_ADDR_W-1:0] addr);
    return addr[PROC_ADDR_W-1:OFF_W];
  endfunction

  function automatic logic [OFF_W-1:0] word_off(input logic [PROC_ADDR_W-1:0] addr);
    return addr[OFF_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
    return line[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Per-line valid/dirty/tag/data storage with one write port (word store or
// full-line fill) and a combinational read of the addressed line.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = $clog2(NUM_BLOCKS),
  parameter int TAG_W      = MEM_ADDR_W - IDX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [LINE_W-1:0]   rd_line,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic                word_we,
  input  logic [OFF_W-1:0]    word_sel,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [LINE_W-1:0]   fill_line
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // Only the state bits are reset; tag and data are qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[wr_idx]  <= fill_tag;
      data_q[wr_idx] <= fill_line;
    end else if (word_we) begin
      data_q[wr_idx][word_sel*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache: miss FSM, hit compare,
// CPU response muxing and the 128-bit block memory request interface.
module dcache_dm_wb
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic [PROC_ADDR_W-1:0] proc_addr,
  input  logic [WORD_W-1:0]     proc_wdata,
  output logic                  proc_stall,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_W-1:0]     mem_rdata
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;

  state_t                state;
  logic [MEM_ADDR_W-1:0] req_blk;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              req, hit, word_we, fill_we;

  assign idx = proc_addr[IDX_W+1:OFF_W];
  assign tag = proc_addr[PROC_ADDR_W-1:IDX_W+OFF_W];
  assign req = proc_read | proc_write;
  assign hit = rd_valid & (rd_tag == tag);

  // A simultaneous read+write is handled as a write.
  assign word_we = (state == ST_IDLE) & proc_write & hit;
  assign fill_we = (state == ST_ALLOCATE) & mem_ready;

  // Gated by rst_n so an in-flight request is released the moment reset asserts.
  assign proc_stall = rst_n & ((state != ST_IDLE) | (req & ~hit));
  assign proc_rdata = (rst_n && state == ST_IDLE && proc_read && !proc_write && hit)
                      ? line_word(rd_line, word_off(proc_addr)) : '0;

  dcache_line_store #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_idx    (fill_we ? req_blk[IDX_W-1:0] : idx),
    .word_we   (word_we),
    .word_sel  (word_off(proc_addr)),
    .word_data (proc_wdata),
    .fill_we   (fill_we),
    .fill_tag  (req_blk[MEM_ADDR_W-1:IDX_W]),
    .fill_line (mem_rdata)
  );

  // The missing block address is latched so the refill completes correctly
  // even if the CPU drops its request mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_blk   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req && !hit) begin
            req_blk <= blk_addr(proc_addr);
            if (rd_valid && rd_dirty) begin
              state     <= ST_WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {rd_tag, idx};
              mem_wdata <= rd_line;
            end else begin
              state    <= ST_ALLOCATE;
              mem_read <= 1'b1;
              mem_addr <= blk_addr(proc_addr);
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ready) begin
            state     <= ST_ALLOCATE;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= req_blk;
          end
        end
        ST_ALLOCATE: begin
          if (mem_ready) begin
            state    <= ST_IDLE;
            mem_read <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Directed bench for dcache_dm_wb: a line-level cache model plus a backing
// memory model predict every output cycle by cycle during each access.
module tb_dcache_dm_wb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  // cache model (8 lines, tag = addr[29:5])
  bit           mv [8];
  bit           md [8];
  logic [24:0]  mt [8];
  logic [127:0] ml [8];
  logic [127:0] mem_store [logic [27:0]];

  // observations of the most recent access, pinned against literals
  logic [31:0]  last_rdata;
  logic [27:0]  last_wb_addr, last_alloc_addr;
  logic [127:0] last_wb_wdata;
  bit           last_wb, last_miss;

  always #5 clk = ~clk;

  dcache_dm_wb #(.NUM_BLOCKS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mem_get(input logic [27:0] b);
    if (mem_store.exists(b)) return mem_store[b];
    return {b[15:0], 16'h3333, b[15:0], 16'h2222, b[15:0], 16'h1111, b[15:0], 16'h0000};
  endfunction

  // One memory phase: the state lasts lat+1 cycles, mem_ready in the last one.
  task automatic mem_phase(input bit wb, input logic [27:0] exp_addr, input int lat,
                           input logic [127:0] exp_wdata);
    for (int c = 0; c <= lat; c++) begin
      @(posedge clk); #1;
      mem_ready = (c == lat);
      mem_rdata = wb ? 128'h0 : mem_get(exp_addr);
      @(negedge clk);
      chk("phase_stall", proc_stall, 1);
      chk("phase_mem_write", mem_write, wb);
      chk("phase_mem_read", mem_read, !wb);
      chk("phase_mem_addr", mem_addr, exp_addr);
      if (wb) chk("phase_mem_wdata", mem_wdata, exp_wdata);
    end
    if (wb) begin
      last_wb_addr  = mem_addr;
      last_wb_wdata = mem_wdata;
    end else begin
      last_alloc_addr = mem_addr;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the request still driven.
  task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                        input logic [31:0] wd, input int lat);
    logic [2:0]  idx;
    logic [24:0] tg;
    logic [1:0]  off;
    bit          hit;
    idx = a[4:2]; tg = a[29:5]; off = a[1:0];
    hit = mv[idx] && (mt[idx] == tg);
    last_wb = 0; last_miss = !hit;
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
    @(negedge clk);
    chk("first_stall", proc_stall, !hit);
    chk("first_mem_read", mem_read, 0);
    chk("first_mem_write", mem_write, 0);
    if (hit && !wr) begin
      chk("hit_rdata", proc_rdata, ml[idx][off*32 +: 32]);
      last_rdata = proc_rdata;
    end
    if (!hit) begin
      if (mv[idx] && md[idx]) begin
        last_wb = 1;
        mem_phase(1, {mt[idx], idx}, lat, ml[idx]);
        mem_store[{mt[idx], idx}] = ml[idx];
      end
      mem_phase(0, a[29:2], lat, 128'h0);
      @(posedge clk); #1;
      mem_ready = 0;
      mv[idx] = 1; md[idx] = 0; mt[idx] = tg; ml[idx] = mem_get(a[29:2]);
      @(negedge clk);
      chk("after_fill_stall", proc_stall, 0);
      chk("after_fill_mem_read", mem_read, 0);
      chk("after_fill_mem_write", mem_write, 0);
      if (!wr) begin
        chk("fill_rdata", proc_rdata, ml[idx][off*32 +: 32]);
        last_rdata = proc_rdata;
      end
    end
    @(posedge clk); #1;
    if (wr) begin
      ml[idx][off*32 +: 32] = wd;
      md[idx] = 1;
    end
  endtask

  task automatic idle(input int n);
    proc_read = 0; proc_write = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_stall", proc_stall, 0);
      chk("idle_mem_req", {mem_read, mem_write}, 2'b00);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 0; proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; mt[i] = '0; ml[i] = '0; end
    mem_store[28'h4] = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    #3;
    chk("reset_stall", proc_stall, 0);
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_rdata", proc_rdata, 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;

    // clean read miss, refill ready after 3 wait cycles
    access(1, 0, 30'h10, 0, 3);
    chk("t1_miss", last_miss, 1);
    chk("t1_alloc_addr", last_alloc_addr, 28'h4);
    chk("t1_rdata_w0", last_rdata, 32'h00000000);
    // immediate hit
    access(1, 0, 30'h12, 0, 3);
    chk("t2_hit", last_miss, 0);
    chk("t2_rdata_w2", last_rdata, 32'h22222222);
    // write hit then conflicting read evicts dirty line
    access(0, 1, 30'h11, 32'hDEADBEEF, 1);
    chk("t3_write_hit", last_miss, 0);
    access(1, 0, 30'h30, 0, 2);
    chk("t3_wb", last_wb, 1);
    chk("t3_wb_addr", last_wb_addr, 28'h4);
    chk("t3_wb_word1", last_wb_wdata[63:32], 32'hDEADBEEF);
    chk("t3_alloc_addr", last_alloc_addr, 28'hC);
    idle(1);
    // write miss on an invalid line: allocate only
    access(0, 1, 30'h44, 32'h12345678, 2);
    chk("t4_no_wb", last_wb, 0);
    chk("t4_alloc_addr", last_alloc_addr, 28'h11);
    access(1, 0, 30'h04, 0, 0);
    chk("t4_wb_addr", last_wb_addr, 28'h11);
    chk("t4_wb_word0", last_wb_wdata[31:0], 32'h12345678);
    // read+write together acts as a write
    access(1, 1, 30'h31, 32'hCAFEF00D, 1);
    access(1, 0, 30'h31, 0, 1);
    chk("rw_as_write", last_rdata, 32'hCAFEF00D);
    access(1, 0, 30'h10, 0, 1);
    chk("rw_wb_addr", last_wb_addr, 28'hC);
    chk("rw_wb_word1", last_wb_wdata[63:32], 32'hCAFEF00D);
    chk("rw_refill_w0", last_rdata, 32'h00000000);
    idle(2);

    // reset in the middle of an allocate
    proc_read = 1; proc_write = 0; proc_addr = 30'h50;
    @(negedge clk);
    chk("t5_miss_stall", proc_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_alloc_mem_read", mem_read, 1);
    chk("t5_alloc_mem_addr", mem_addr, 28'h14);
    #2 rst_n = 0;
    #1;
    chk("t5_rst_mem_read", mem_read, 0);
    chk("t5_rst_stall", proc_stall, 0);
    chk("t5_rst_mem_addr", mem_addr, 0);
    for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; end
    proc_read = 0;
    @(posedge clk); #1; rst_n = 1;

    // stray mem_ready while idle
    @(posedge clk); #1; mem_ready = 1; mem_rdata = '1;
    @(negedge clk);
    chk("t6_stall", proc_stall, 0);
    chk("t6_mem_req", {mem_read, mem_write}, 2'b00);
    @(posedge clk); #1; mem_ready = 0;
    idle(1);
    access(1, 0, 30'h10, 0, 1);
    chk("t6_miss_after_reset", last_miss, 1);
    chk("t6_rdata_w0", last_rdata, 32'h00000000);
    access(1, 0, 30'h13, 0, 1);
    chk("t6_rdata_w3", last_rdata, 32'h33333333);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
